store_check_monitor: RTL and testbench
======================================

Name: store_check_monitor

Overview:
Synthesizable store-stream checker for the MIPS core's data-memory write port (memwrite, dataadr, writedata). It replaces the single-value pass/fail bench check with a loadable table of up to DEPTH expected {address, data} stores, a configurable ignore address, an ordered/unordered match mode and a cycle timeout. Pass, fail and timeout are reported as sticky status with failure capture, for use in benches or an FPGA self-test wrapper next to TopMIPS.

Parameters:
WIDTH, 32, width of dataadr/writedata and of table entries
DEPTH, 8, number of expected-store table entries (power of 2, >=2)
TIMEOUT, 1000, RUN cycles before timeout; 0 disables timeout
ORDERED, 1, 1 = any non-ignored mismatching store fails; 0 = mismatching stores are skipped and counted

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
memwrite  in  1  core store strobe
dataadr  in  WIDTH  core store address
writedata  in  WIDTH  core store data
cfg_we  in  1  table write enable (honoured only in IDLE)
cfg_idx  in  $clog2(DEPTH)  table entry index
cfg_addr  in  WIDTH  expected address for entry
cfg_data  in  WIDTH  expected data for entry
cfg_count  in  $clog2(DEPTH)+1  number of entries to check, latched at start
ign_en  in  1  enable ignore address
ign_addr  in  WIDTH  stores to this address are ignored
start  in  1  single-cycle pulse: begin check
busy  out  1  high in RUN
done  out  1  high in PASS, FAIL or TMO
pass  out  1  high in PASS
fail  out  1  high in FAIL
timeout  out  1  high in TMO
fail_idx  out  $clog2(DEPTH)  table pointer at failure
fail_addr  out  WIDTH  captured dataadr of failing store
fail_data  out  WIDTH  captured writedata of failing store
store_cnt  out  16  non-ignored stores seen in current run (saturating)
skip_cnt  out  16  mismatching stores skipped (ORDERED=0), saturating

Behaviour:
- States: IDLE, RUN, PASS, FAIL, TMO. Reset -> IDLE; all outputs 0; table, pointer, counters and capture registers cleared to 0.
- IDLE: cfg_we writes table[cfg_idx] <= {cfg_addr, cfg_data} on the edge. start -> RUN next cycle: latch count = min(cfg_count, DEPTH); clear ptr, cycle counter, store_cnt, skip_cnt and capture registers. If latched count = 0, go to PASS instead.
- RUN: cycle counter increments every cycle. Each cycle with memwrite=1:
  - ign_en && dataadr == ign_addr: ignored; no counters change.
  - Otherwise store_cnt++. If {dataadr, writedata} == table[ptr] (full-width compare), it is a match: ptr++. If ptr == count-1 before the increment -> PASS.
  - On mismatch with ORDERED=1: FAIL; fail_idx <= ptr, fail_addr <= dataadr, fail_data <= writedata.
  - On mismatch with ORDERED=0: skip_cnt++ and stay in RUN.
- Timeout: if TIMEOUT != 0 and cycle counter reaches TIMEOUT-1 with no terminal transition, go to TMO. A store evaluated on that same cycle takes priority, so PASS/FAIL wins over TMO.
- Status is visible one cycle after the deciding edge (registered outputs). busy = (state == RUN).
- PASS, FAIL and TMO are sticky until reset or start. start in a done state re-enters RUN with the same clears. The table is retained.
- In RUN, start and cfg_we are ignored. memwrite is ignored outside RUN.
- Reset asserted mid-run returns to IDLE on the next edge and clears everything, including the table.
- Counters saturate at 16'hFFFF; no wrap.

Test Plan:
- Load entry0 = {84, 32'hFFFF7F02}, count = 1, ign_en = 1, ign_addr = 80, start. Stores (80, 7) then (84, 32'hFFFF7F02) -> pass = 1 and done = 1 one cycle after the second store; store_cnt = 1.
- Same setup, stores (80, 7) then (84, 32'hFFFF7F03) -> fail = 1, fail_idx = 0, fail_addr = 84, fail_data = 32'hFFFF7F03.
- ORDERED=0, entries {0, 5}, {4, 9}, count = 2. Stores (0, 5), (8, 1), (4, 9) -> pass; skip_cnt = 1, store_cnt = 3.
- TIMEOUT = 20, start with no stores -> timeout = 1 on cycle 21 after start; pass = fail = 0. Then start again with a matching store -> counters cleared, pass = 1.
- Store matching the last entry on cycle TIMEOUT-1 -> pass = 1, timeout = 0. cfg_count = 0 -> pass one cycle after start.
- Reset asserted mid-RUN -> IDLE next edge, all outputs 0. cfg_we during RUN leaves the table unchanged; check by rerunning the prior passing stream.

Source files
------------

// File: rtl/store_check_monitor.sv
// Store-stream checker for the MIPS data-memory write port: compares core stores
// against a loadable {address, data} table and reports sticky pass/fail/timeout.
module store_check_monitor #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  parameter int ORDERED = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]           cfg_addr,
  input  logic [WIDTH-1:0]           cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_count,
  input  logic                       ign_en,
  input  logic [WIDTH-1:0]           ign_addr,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [WIDTH-1:0]           fail_addr,
  output logic [WIDTH-1:0]           fail_data,
  output logic [15:0]                store_cnt,
  output logic [15:0]                skip_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tab_addr [DEPTH];
  logic [WIDTH-1:0] r_tab_data [DEPTH];
  logic [IW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_cyc;
  logic             r_busy, r_done, r_pass, r_fail, r_tmo;
  logic [IW-1:0]    r_fail_idx;
  logic [WIDTH-1:0] r_fail_addr, r_fail_data;
  logic [15:0]      r_store_cnt, r_skip_cnt;

  logic             w_store, w_match, w_last, w_tmo;
  logic [CW-1:0]    w_cnt_lat;

  always_comb begin
    w_store   = memwrite && !(ign_en && (dataadr == ign_addr));
    w_match   = (dataadr == r_tab_addr[r_ptr]) && (writedata == r_tab_data[r_ptr]);
    w_last    = ({1'b0, r_ptr} == (r_count - CW'(1)));
    w_tmo     = (TIMEOUT != 0) && (r_cyc == 32'(TIMEOUT - 1));
    w_cnt_lat = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;
  end

  // A store decided on the timeout cycle takes priority over TMO.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        if (w_store && w_match && w_last)
          w_next = S_PASS;
        else if (w_store && !w_match && (ORDERED != 0))
          w_next = S_FAIL;
        else if (w_tmo)
          w_next = S_TMO;
      end
      default: begin
        if (start)
          w_next = (w_cnt_lat == '0) ? S_PASS : S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tab_addr[i] <= '0;
        r_tab_data[i] <= '0;
      end
    end else if (r_state == S_IDLE && cfg_we) begin
      r_tab_addr[cfg_idx] <= cfg_addr;
      r_tab_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_tmo       <= 1'b0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_cyc       <= '0;
      r_fail_idx  <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_store_cnt <= '0;
      r_skip_cnt  <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_PASS) || (w_next == S_FAIL) || (w_next == S_TMO);
      r_pass  <= (w_next == S_PASS);
      r_fail  <= (w_next == S_FAIL);
      r_tmo   <= (w_next == S_TMO);
      if (r_state != S_RUN) begin
        if (start) begin
          r_count     <= w_cnt_lat;
          r_ptr       <= '0;
          r_cyc       <= '0;
          r_store_cnt <= '0;
          r_skip_cnt  <= '0;
          r_fail_idx  <= '0;
          r_fail_addr <= '0;
          r_fail_data <= '0;
        end
      end else begin
        if (r_cyc != '1)
          r_cyc <= r_cyc + 32'd1;
        if (w_store) begin
          if (r_store_cnt != '1)
            r_store_cnt <= r_store_cnt + 16'd1;
          if (w_match) begin
            r_ptr <= r_ptr + IW'(1);
          end else if (ORDERED != 0) begin
            r_fail_idx  <= r_ptr;
            r_fail_addr <= dataadr;
            r_fail_data <= writedata;
          end else if (r_skip_cnt != '1) begin
            r_skip_cnt <= r_skip_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_tmo;
  assign fail_idx  = r_fail_idx;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign store_cnt = r_store_cnt;
  assign skip_cnt  = r_skip_cnt;

endmodule

// File: tb/tb_store_check_monitor.sv
// Bench for store_check_monitor: ordered and unordered instances share stimulus and
// are checked against a store-list walk of the expected table.
module tb_store_check_monitor;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset, memwrite, cfg_we, ign_en, start;
  logic [W-1:0]  dataadr, writedata, cfg_addr, cfg_data, ign_addr;
  logic [2:0]    cfg_idx;
  logic [3:0]    cfg_count;

  logic          busy_o, done_o, pass_o, fail_o, tmo_o;
  logic [2:0]    fidx_o;
  logic [W-1:0]  faddr_o, fdata_o;
  logic [15:0]   scnt_o, kcnt_o;
  logic          busy_u, done_u, pass_u, fail_u, tmo_u;
  logic [2:0]    fidx_u;
  logic [W-1:0]  faddr_u, fdata_u;
  logic [15:0]   scnt_u, kcnt_u;

  always #5 clk = ~clk;

  store_check_monitor #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .ign_en(ign_en), .ign_addr(ign_addr), .start(start),
    .busy(busy_o), .done(done_o), .pass(pass_o), .fail(fail_o), .timeout(tmo_o),
    .fail_idx(fidx_o), .fail_addr(faddr_o), .fail_data(fdata_o),
    .store_cnt(scnt_o), .skip_cnt(kcnt_o));

  store_check_monitor #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .ORDERED(0)) u_uno (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .ign_en(ign_en), .ign_addr(ign_addr), .start(start),
    .busy(busy_u), .done(done_u), .pass(pass_u), .fail(fail_u), .timeout(tmo_u),
    .fail_idx(fidx_u), .fail_addr(faddr_u), .fail_data(fdata_u),
    .store_cnt(scnt_u), .skip_cnt(kcnt_u));

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_addr [D];
  logic [W-1:0] m_data [D];
  int           s_len;
  logic         s_mw [32];
  logic [W-1:0] s_a  [32];
  logic [W-1:0] s_d  [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_s();
    s_len = 0;
  endtask

  task automatic add_s(input logic mw, input logic [W-1:0] a, input logic [W-1:0] d);
    if (s_len < 32) begin
      s_mw[s_len] = mw;
      s_a[s_len]  = a;
      s_d[s_len]  = d;
      s_len++;
    end
  endtask

  // Walks the store list in run-cycle order; res: 1 pass, 2 fail, 3 timeout.
  task automatic model(input int ordered, input int cnt, input logic ien, input logic [W-1:0] iad,
                       output int dcyc, output int res, output int sc, output int kc,
                       output int fidx, output logic [W-1:0] fa, output logic [W-1:0] fd);
    int ptr;
    ptr = 0; sc = 0; kc = 0; fidx = 0; fa = '0; fd = '0; res = 0; dcyc = -1;
    if (cnt == 0) begin
      res = 1;
      return;
    end
    for (int j = 0; j < TO && res == 0; j++) begin
      if (j < s_len && s_mw[j] && !(ien && s_a[j] == iad)) begin
        sc++;
        if (s_a[j] == m_addr[ptr] && s_d[j] == m_data[ptr]) begin
          ptr++;
          if (ptr == cnt) res = 1;
        end else if (ordered != 0) begin
          res = 2; fidx = ptr; fa = s_a[j]; fd = s_d[j];
        end else begin
          kc++;
        end
      end
      if (res == 0 && j == TO - 1) res = 3;
      if (res != 0) dcyc = j;
    end
  endtask

  task automatic cmp(input string p, input int ordered, input int cnt, input logic ien,
                     input logic [W-1:0] iad, input int dn, input logic b, input logic dne,
                     input logic ps, input logic fl, input logic tm, input logic [2:0] fi,
                     input logic [W-1:0] fa, input logic [W-1:0] fd,
                     input logic [15:0] sc, input logic [15:0] kc);
    int e_dc, e_res, e_sc, e_kc, e_fi;
    logic [W-1:0] e_fa, e_fd;
    model(ordered, cnt, ien, iad, e_dc, e_res, e_sc, e_kc, e_fi, e_fa, e_fd);
    check({p, ".done_cycle"}, dn, e_dc);
    check({p, ".busy"}, b, 0);
    check({p, ".done"}, dne, 1);
    check({p, ".pass"}, ps, e_res == 1);
    check({p, ".fail"}, fl, e_res == 2);
    check({p, ".timeout"}, tm, e_res == 3);
    check({p, ".store_cnt"}, sc, e_sc);
    check({p, ".skip_cnt"}, kc, e_kc);
    check({p, ".fail_idx"}, fi, e_fi);
    check({p, ".fail_addr"}, fa, e_fa);
    check({p, ".fail_data"}, fd, e_fd);
  endtask

  task automatic zero_chk(input string p, input logic b, input logic dne, input logic ps,
                          input logic fl, input logic tm, input logic [2:0] fi,
                          input logic [W-1:0] fa, input logic [W-1:0] fd,
                          input logic [15:0] sc, input logic [15:0] kc);
    check({p, ".busy"}, b, 0);
    check({p, ".done"}, dne, 0);
    check({p, ".pass"}, ps, 0);
    check({p, ".fail"}, fl, 0);
    check({p, ".timeout"}, tm, 0);
    check({p, ".fail_idx"}, fi, 0);
    check({p, ".fail_addr"}, fa, 0);
    check({p, ".fail_data"}, fd, 0);
    check({p, ".store_cnt"}, sc, 0);
    check({p, ".skip_cnt"}, kc, 0);
  endtask

  task automatic do_reset(input string p);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < D; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    zero_chk({p, ".ord"}, busy_o, done_o, pass_o, fail_o, tmo_o, fidx_o, faddr_o, fdata_o, scnt_o, kcnt_o);
    zero_chk({p, ".uno"}, busy_u, done_u, pass_u, fail_u, tmo_u, fidx_u, faddr_u, fdata_u, scnt_u, kcnt_u);
  endtask

  task automatic load(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
    m_addr[idx] = a;
    m_data[idx] = d;
  endtask

  task automatic run_test(input string nm, input int cfgc, input logic ien,
                          input logic [W-1:0] iad, input bit junk);
    int cnt, dn_o, dn_u;
    cnt  = (cfgc > D) ? D : cfgc;
    dn_o = -2;
    dn_u = -2;
    ign_en = ien; ign_addr = iad; cfg_count = 4'(cfgc); start = 1'b1;
    step();
    start = 1'b0;
    check({nm, ".ord.busy_at_start"}, busy_o, cnt != 0);
    check({nm, ".uno.busy_at_start"}, busy_u, cnt != 0);
    if (done_o) dn_o = -1;
    if (done_u) dn_u = -1;
    for (int j = 0; j < TO + 2; j++) begin
      memwrite  = (j < s_len) ? s_mw[j] : 1'b0;
      dataadr   = (j < s_len) ? s_a[j] : '0;
      writedata = (j < s_len) ? s_d[j] : '0;
      if (junk) begin
        cfg_we = 1'b1; cfg_idx = 3'(j); cfg_addr = $urandom; cfg_data = $urandom;
      end
      step();
      if (done_o && dn_o == -2) dn_o = j;
      if (done_u && dn_u == -2) dn_u = j;
    end
    memwrite = 1'b0; cfg_we = 1'b0;
    cmp({nm, ".ord"}, 1, cnt, ien, iad, dn_o, busy_o, done_o, pass_o, fail_o, tmo_o,
        fidx_o, faddr_o, fdata_o, scnt_o, kcnt_o);
    cmp({nm, ".uno"}, 0, cnt, ien, iad, dn_u, busy_u, done_u, pass_u, fail_u, tmo_u,
        fidx_u, faddr_u, fdata_u, scnt_u, kcnt_u);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; cfg_we = 1'b0; ign_en = 1'b0; start = 1'b0;
    dataadr = '0; writedata = '0; cfg_addr = '0; cfg_data = '0; ign_addr = '0;
    cfg_idx = '0; cfg_count = '0;
    step();
    do_reset("por");

    load(0, 32'd84, 32'hFFFF7F02);
    clr_s(); add_s(1, 32'd80, 32'd7); add_s(1, 32'd84, 32'hFFFF7F02);
    run_test("pass1", 1, 1'b1, 32'd80, 0);
    clr_s(); add_s(1, 32'd80, 32'd7); add_s(1, 32'd84, 32'hFFFF7F03);
    run_test("fail1", 1, 1'b1, 32'd80, 0);
    clr_s();
    run_test("tmo", 1, 1'b1, 32'd80, 0);
    clr_s(); add_s(1, 32'd84, 32'hFFFF7F02);
    run_test("restart", 1, 1'b1, 32'd80, 0);
    clr_s();
    for (int j = 0; j < TO - 1; j++) add_s(0, '0, '0);
    add_s(1, 32'd84, 32'hFFFF7F02);
    run_test("last_cycle", 1, 1'b0, 32'd0, 0);
    clr_s();
    run_test("count0", 0, 1'b0, 32'd0, 0);
    clr_s(); add_s(1, 32'd80, 32'd7); add_s(1, 32'd84, 32'hFFFF7F02);
    run_test("we_in_run", 1, 1'b1, 32'd80, 1);
    run_test("rerun", 1, 1'b1, 32'd80, 0);

    cfg_count = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    do_reset("midrun");

    load(0, 32'd0, 32'd5);
    load(1, 32'd4, 32'd9);
    clr_s(); add_s(1, 32'd0, 32'd5); add_s(1, 32'd8, 32'd1); add_s(1, 32'd4, 32'd9);
    run_test("skip", 2, 1'b0, 32'd0, 0);

    for (int e = 0; e < 6; e++) begin
      do_reset("epoch");
      for (int i = 0; i < D; i++) load(i, 32'(4 * $urandom_range(0, 7)), 32'($urandom_range(0, 3)));
      for (int r = 0; r < 8; r++) begin
        int gc, len, k;
        logic [W-1:0] iad;
        iad = 32'(4 * $urandom_range(0, 7));
        gc  = 0;
        len = $urandom_range(0, 20);
        clr_s();
        for (int j = 0; j < len; j++) begin
          k = $urandom_range(0, 9);
          if (k < 4) begin
            add_s(1, m_addr[gc % D], m_data[gc % D]);
            gc++;
          end else if (k < 5) begin
            add_s(1, iad, 32'($urandom_range(0, 3)));
          end else if (k < 7) begin
            add_s(1, 32'(4 * $urandom_range(0, 7)), 32'($urandom_range(0, 3)));
          end else begin
            add_s(0, 32'($urandom), 32'($urandom));
          end
        end
        run_test("rand", $urandom_range(0, 10), 1'($urandom_range(0, 1)), iad,
                 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
